// File: rtl/m31_ext_linear_layer.sv
// m31_ext_linear_layer
//   Poseidon2 external linear layer over the Mersenne-31 field (P = 2^31-1),
//   two register stages with valid/ready handshake and full backpressure.
//     stage 1 : M4 = [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] applied to every 4-lane block
//     stage 2 : z[4b+i] = y[4b+i] + sum_b y[4b+i]  (circ(2*M4, M4, ..., M4))
//   Optional feature macro: M31_EXT_LIN_ERR_EN (adds sticky err_o for lanes equal to P).
//
// Ports
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   in_valid_i   input state valid
//   in_ready_o   input accepted this cycle when high (combinational, ~stall)
//   state_i      WIDTH lanes x 31 bits, lane l at [31*l +: 31]
//   out_valid_o  output state valid
//   out_ready_i  downstream accepts output
//   err_o        sticky non-canonical input flag (only with M31_EXT_LIN_ERR_EN)
//   state_o      WIDTH lanes x 31 bits, lane l at [31*l +: 31]

module m31_ext_linear_layer #(
  parameter int WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH*31-1:0]  state_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
`ifdef M31_EXT_LIN_ERR_EN
  output logic                 err_o,
`endif
  output logic [WIDTH*31-1:0]  state_o
);

  localparam int NBLK = WIDTH / 4;
  localparam logic [30:0] P = 31'h7FFFFFFF;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 24) begin : g_bad_width
    $error("m31_ext_linear_layer: WIDTH must be a multiple of 4 in 4..24");
  end

  // Operands are always canonical here, so the raw sum is at most 2P-2:
  // folding the carry back in (2^31 == 1 mod P) leaves at most P, which maps to 0.
  function automatic logic [30:0] m31_add(input logic [30:0] a, input logic [30:0] b);
    logic [31:0] sum;
    logic [30:0] fold;
    sum  = {1'b0, a} + {1'b0, b};
    fold = sum[30:0] + {30'd0, sum[31]};
    return (fold == P) ? 31'd0 : fold;
  endfunction

  // Doubling mod 2^31-1 is a 1-bit rotate.
  function automatic logic [30:0] m31_dbl(input logic [30:0] a);
    return {a[29:0], a[30]};
  endfunction

  function automatic logic [30:0] m31_canon(input logic [30:0] a);
    return (a == P) ? 31'd0 : a;
  endfunction

  function automatic logic [123:0] m4_apply(input logic [123:0] x);
    logic [30:0] x0, x1, x2, x3;
    logic [30:0] t01, t23, t0123, t01123, t01233;
    logic [30:0] y0, y1, y2, y3;
    x0     = m31_canon(x[30:0]);
    x1     = m31_canon(x[61:31]);
    x2     = m31_canon(x[92:62]);
    x3     = m31_canon(x[123:93]);
    t01    = m31_add(x0, x1);
    t23    = m31_add(x2, x3);
    t0123  = m31_add(t01, t23);
    t01123 = m31_add(t0123, x1);
    t01233 = m31_add(t0123, x3);
    y0     = m31_add(t01123, t01);
    y1     = m31_add(t01123, m31_dbl(x2));
    y2     = m31_add(t01233, t23);
    y3     = m31_add(t01233, m31_dbl(x0));
    return {y3, y2, y1, y0};
  endfunction

  // Balanced pairwise tree over 8 slots; unused slots are zero.
  function automatic logic [30:0] tree_sum(input logic [247:0] v);
    logic [30:0] acc [8];
    for (int k = 0; k < 8; k++) acc[k] = v[31*k +: 31];
    for (int step = 1; step < 8; step = step * 2) begin
      for (int k = 0; k < 8; k = k + 2 * step) begin
        acc[k] = m31_add(acc[k], acc[k+step]);
      end
    end
    return acc[0];
  endfunction

  logic                 stall;
  logic                 v1_q;
  logic [WIDTH*31-1:0]  y_d;
  logic [WIDTH*31-1:0]  y_q;
  logic [WIDTH*31-1:0]  z_d;
  logic [247:0]         gath;
  logic [30:0]          col;

  assign stall      = out_valid_o & ~out_ready_i;
  assign in_ready_o = ~stall;

  always_comb begin
    y_d = '0;
    for (int b = 0; b < NBLK; b++) begin
      y_d[124*b +: 124] = m4_apply(state_i[124*b +: 124]);
    end
  end

  // With a single block there is no column mixing: y passes straight through.
  always_comb begin
    z_d  = y_q;
    gath = '0;
    col  = '0;
    if (NBLK > 1) begin
      for (int i = 0; i < 4; i++) begin
        gath = '0;
        for (int b = 0; b < NBLK; b++) begin
          gath[31*b +: 31] = y_q[124*b + 31*i +: 31];
        end
        col = tree_sum(gath);
        for (int b = 0; b < NBLK; b++) begin
          z_d[124*b + 31*i +: 31] = m31_add(y_q[124*b + 31*i +: 31], col);
        end
      end
    end
  end

  // Both stages advance together whenever the output is not stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q        <= 1'b0;
      y_q         <= '0;
      out_valid_o <= 1'b0;
      state_o     <= '0;
    end else if (!stall) begin
      v1_q        <= in_valid_i;
      out_valid_o <= v1_q;
      if (in_valid_i) y_q <= y_d;
      if (v1_q) state_o <= z_d;
    end
  end

`ifdef M31_EXT_LIN_ERR_EN
  logic lane_is_p;

  always_comb begin
    lane_is_p = 1'b0;
    for (int l = 0; l < WIDTH; l++) begin
      if (state_i[31*l +: 31] == P) lane_is_p = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (in_valid_i && in_ready_o && lane_is_p) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule
